// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the push-button / DIP-switch conditioning front end.
package input_conditioner_pkg;

    // Post clk_div system clock
    localparam int unsigned CLK_FREQ_HZ     = 25_000_000;

    // Default timing and channel counts
    localparam int unsigned DEBOUNCE_MS_DEF = 20;
    localparam int unsigned HOLD_MS_DEF     = 1000;
    localparam int unsigned N_BTN_DEF       = 4;
    localparam int unsigned N_SW_DEF        = 8;

    // Operator button positions within btn_raw / btn_level / btn_pulse / btn_hold
    typedef enum int unsigned {
        BTN_CONFIRM = 0,
        BTN_BACK    = 1,
        BTN_NEXT    = 2,
        BTN_PREV    = 3
    } btn_idx_e;

    // Milliseconds to clock cycles; divide first so large frequencies stay in 32 bits
    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// One conditioning channel: 2-flop synchroniser followed by a stable-time debouncer.
module input_conditioner_debounce_cell #(
    parameter int unsigned DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic          meta;
    logic          sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the raw pin into clk; sync is the second flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Accept a new level only after DB_CYC consecutive samples that disagree with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYC - 1)) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign level = stable;

endmodule

// File: rtl/input_conditioner.sv
// Synchronise and debounce operator buttons and DIP switches; derive press, hold and change pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = CLK_FREQ_HZ,
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int unsigned HOLD_MS     = HOLD_MS_DEF,
    parameter int unsigned N_BTN       = N_BTN_DEF,
    parameter int unsigned N_SW        = N_SW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_hold,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_changed
);

    localparam int unsigned DB_CYC   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned HOLD_CYC = ms_to_cycles(CLK_FREQ, HOLD_MS);
    localparam int unsigned HW       = $clog2(HOLD_CYC + 1);
    localparam int unsigned N_CH     = N_BTN + N_SW;

    // Timing too short to debounce or detect a hold is a configuration error
    if (DB_CYC < 2) begin : g_bad_db
        $error("input_conditioner: DB_CYC must be >= 2");
    end
    if (HOLD_CYC < 2) begin : g_bad_hold
        $error("input_conditioner: HOLD_CYC must be >= 2");
    end

    logic [N_CH-1:0] raw_all;
    logic [N_CH-1:0] level_all;

    assign raw_all = {sw_raw, btn_raw};

    // Buttons occupy the low channels, switches the high ones; every channel is independent
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        input_conditioner_debounce_cell #(
            .DB_CYC (DB_CYC)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_all[ch]),
            .level (level_all[ch])
        );
    end

    // Debounced levels come straight from the stable registers inside the cells
    assign btn_level = level_all[N_BTN-1:0];
    assign sw_level  = level_all[N_CH-1:N_BTN];

    logic [N_BTN-1:0] btn_prev;
    logic [N_SW-1:0]  sw_prev;
    logic [HW-1:0]    hold_cnt [N_BTN];

    // Press pulse: one cycle after the debounced level rises, nothing on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev  <= '0;
            btn_pulse <= '0;
        end else begin
            btn_prev  <= btn_level;
            btn_pulse <= btn_level & ~btn_prev;
        end
    end

    // Hold timer per button: counts while pressed, saturates so each press fires once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                hold_cnt[i] <= '0;
            end
            btn_hold <= '0;
        end else begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (!btn_level[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HW'(HOLD_CYC)) begin
                    hold_cnt[i] <= hold_cnt[i] + HW'(1);
                end
                btn_hold[i] <= btn_level[i] && (hold_cnt[i] == HW'(HOLD_CYC - 1));
            end
        end
    end

    // Switch change: any bits accepted on the same edge merge into one pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_prev    <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_prev    <= sw_level;
            sw_changed <= |(sw_level ^ sw_prev);
        end
    end

endmodule
